// File: rtl/msrv32_lsu_ctrl_if.sv
// Data-memory request/response bus between the msrv32 load/store unit (master) and the
// data memory (slave).
interface msrv32_lsu_ctrl_if;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic [3:0]  dmem_wmask_out;
    logic [31:0] dmem_rdata_in;
    logic        dmem_ack_in;

    modport master (
        output dmem_req_out,
        output dmem_we_out,
        output dmem_addr_out,
        output dmem_wdata_out,
        output dmem_wmask_out,
        input  dmem_rdata_in,
        input  dmem_ack_in
    );

    modport slave (
        input  dmem_req_out,
        input  dmem_we_out,
        input  dmem_addr_out,
        input  dmem_wdata_out,
        input  dmem_wmask_out,
        output dmem_rdata_in,
        output dmem_ack_in
    );
endinterface

// File: rtl/msrv32_lsu_ctrl.sv
// msrv32 load/store control: one outstanding data-memory access with lane steering and timeout.
// Define MSRV32_LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with a flag pulse.
module msrv32_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              ld_req_in,
    input  logic              st_req_in,
    input  logic [31:0]       addr_in,
    input  logic [1:0]        load_size_in,
    input  logic              load_unsigned_in,
    input  logic [31:0]       store_data_in,
    msrv32_lsu_ctrl_if.master dmem,
    output logic              lsu_stall_out,
    output logic [31:0]       ld_data_out,
    output logic              ld_valid_out,
    output logic              bus_err_out,
    output logic              misaligned_out
);
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {StIdle, StAccess} state_e;
    state_e state_q, state_d;

    logic [CntW-1:0] cnt_q;
    logic [31:0]     addr_q, wdata_q, ld_data_q;
    logic [3:0]      wmask_q;
    logic [1:0]      size_q, lane_q;
    logic            unsigned_q, we_q, ld_valid_q, bus_err_q;

    logic            any_req, misalign_hit, accept, ack, timeout;
    logic [3:0]      wmask_d;
    logic [31:0]     wdata_d, ld_result;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;

    assign any_req = ld_req_in | st_req_in;

`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
    assign misalign_hit = (load_size_in == 2'b01 && addr_in[0]) ||
                          (load_size_in[1] && addr_in[1:0] != 2'b00);
`else
    assign misalign_hit = 1'b0;
`endif

    assign accept  = (state_q == StIdle) && any_req && !misalign_hit;
    assign ack     = (state_q == StAccess) && dmem.dmem_ack_in;
    // Ack takes priority over an expiring counter in the same cycle.
    assign timeout = (state_q == StAccess) && !dmem.dmem_ack_in && (cnt_q == CntLast);

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StAccess;
            StAccess: if (ack || timeout) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        lsu_stall_out = ((state_q == StIdle) && accept) ||
                        ((state_q == StAccess) && !dmem.dmem_ack_in);
    end

    // Store lane steering from the incoming request.
    always_comb begin
        wmask_d = 4'b0000;
        wdata_d = store_data_in;
        unique case (load_size_in)
            2'b00: begin
                wmask_d = 4'b0001 << addr_in[1:0];
                wdata_d = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                wmask_d = 4'b0011 << {addr_in[1], 1'b0};
                wdata_d = {2{store_data_in[15:0]}};
            end
            default: begin
                wmask_d = 4'b1111;
                wdata_d = store_data_in;
            end
        endcase
        if (ld_req_in) begin
            wmask_d = 4'b0000;
        end
    end

    // Load lane extraction from the returned word.
    always_comb begin
        byte_sel = dmem.dmem_rdata_in[7:0];
        unique case (lane_q)
            2'b00: byte_sel = dmem.dmem_rdata_in[7:0];
            2'b01: byte_sel = dmem.dmem_rdata_in[15:8];
            2'b10: byte_sel = dmem.dmem_rdata_in[23:16];
            2'b11: byte_sel = dmem.dmem_rdata_in[31:24];
            default: byte_sel = dmem.dmem_rdata_in[7:0];
        endcase
        half_sel = lane_q[1] ? dmem.dmem_rdata_in[31:16] : dmem.dmem_rdata_in[15:0];
        unique case (size_q)
            2'b00:   ld_result = {{24{byte_sel[7] & ~unsigned_q}}, byte_sel};
            2'b01:   ld_result = {{16{half_sel[15] & ~unsigned_q}}, half_sel};
            default: ld_result = dmem.dmem_rdata_in;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            we_q       <= 1'b0;
            size_q     <= '0;
            lane_q     <= '0;
            unsigned_q <= 1'b0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q      <= '0;
                addr_q     <= {addr_in[31:2], 2'b00};
                wdata_q    <= wdata_d;
                wmask_q    <= wmask_d;
                we_q       <= ~ld_req_in;
                size_q     <= load_size_in;
                lane_q     <= addr_in[1:0];
                unsigned_q <= load_unsigned_in;
            end else if ((state_q == StAccess) && !dmem.dmem_ack_in) begin
                cnt_q <= cnt_q + CntW'(1);
            end
            ld_valid_q <= ack && !we_q;
            if (ack && !we_q) begin
                ld_data_q <= ld_result;
            end
            bus_err_q <= timeout;
        end
    end

`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
    logic misaligned_q;
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= (state_q == StIdle) && any_req && misalign_hit;
        end
    end
    assign misaligned_out = misaligned_q;
`else
    assign misaligned_out = 1'b0;
`endif

    assign dmem.dmem_req_out   = (state_q == StAccess);
    assign dmem.dmem_we_out    = we_q;
    assign dmem.dmem_addr_out  = addr_q;
    assign dmem.dmem_wdata_out = wdata_q;
    assign dmem.dmem_wmask_out = wmask_q;
    assign ld_data_out         = ld_data_q;
    assign ld_valid_out        = ld_valid_q;
    assign bus_err_out         = bus_err_q;
endmodule

// File: tb/tb_msrv32_lsu_ctrl.sv
// Directed bench for msrv32_lsu_ctrl: transaction-level model checked every cycle plus literal
// expectations for the key scenarios.
module tb_msrv32_lsu_ctrl;
    localparam int unsigned Timeout = 15;
`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
    localparam bit Trap = 1'b1;
`else
    localparam bit Trap = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        ld_req_in = 1'b0;
    logic        st_req_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [1:0]  load_size_in = '0;
    logic        load_unsigned_in = 1'b0;
    logic [31:0] store_data_in = '0;
    logic        lsu_stall_out, ld_valid_out, bus_err_out, misaligned_out;
    logic [31:0] ld_data_out;

    msrv32_lsu_ctrl_if bus ();

    msrv32_lsu_ctrl #(.TIMEOUT_CYCLES(Timeout)) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .ld_req_in        (ld_req_in),
        .st_req_in        (st_req_in),
        .addr_in          (addr_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .store_data_in    (store_data_in),
        .dmem             (bus.master),
        .lsu_stall_out    (lsu_stall_out),
        .ld_data_out      (ld_data_out),
        .ld_valid_out     (ld_valid_out),
        .bus_err_out      (bus_err_out),
        .misaligned_out   (misaligned_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction model state
    logic        m_busy = 1'b0, m_ld = 1'b0, m_uns = 1'b0;
    int unsigned m_waited = 0;
    logic [1:0]  m_size = '0;
    logic [31:0] m_addr = '0;
    logic        e_we = 1'b0, e_valid = 1'b0, e_err = 1'b0, e_mis = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_ld_data = '0;
    logic [3:0]  e_wmask = '0;

    function automatic bit is_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [3:0] f_mask(input logic ld, input logic [1:0] sz,
                                          input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if (ld) return 4'h0;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return 4'(3 << (off & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] f_load(input logic [1:0] sz, input logic uns,
                                           input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int unsigned off;
        off = a % 4;
        if (sz == 2'd0) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'd1) begin
            v = (rd >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    always @(posedge clk_in) begin
        if (!reset_in) begin
            m_busy <= 1'b0; m_waited <= 0;
            e_addr <= '0; e_we <= 1'b0; e_wmask <= '0; e_wdata <= '0;
            e_ld_data <= '0; e_valid <= 1'b0; e_err <= 1'b0; e_mis <= 1'b0;
        end else begin
            e_valid <= 1'b0; e_err <= 1'b0; e_mis <= 1'b0;
            if (m_busy) begin
                if (bus.dmem_ack_in) begin
                    m_busy <= 1'b0;
                    if (m_ld) begin
                        e_ld_data <= f_load(m_size, m_uns, m_addr, bus.dmem_rdata_in);
                        e_valid   <= 1'b1;
                    end
                end else if (m_waited + 1 >= Timeout) begin
                    m_busy <= 1'b0;
                    e_err  <= 1'b1;
                end else begin
                    m_waited <= m_waited + 1;
                end
            end else if (ld_req_in || st_req_in) begin
                if (Trap && is_mis(load_size_in, addr_in)) begin
                    e_mis <= 1'b1;
                end else begin
                    m_busy <= 1'b1; m_waited <= 0;
                    m_ld <= ld_req_in; m_size <= load_size_in;
                    m_uns <= load_unsigned_in; m_addr <= addr_in;
                    e_addr  <= addr_in & ~32'h3;
                    e_we    <= ~ld_req_in;
                    e_wmask <= f_mask(ld_req_in, load_size_in, addr_in);
                    e_wdata <= f_wdata(load_size_in, store_data_in);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        logic e_stall;
        e_stall = m_busy ? !bus.dmem_ack_in :
                  ((ld_req_in || st_req_in) && !(Trap && is_mis(load_size_in, addr_in)));
        chk("req", 32'(bus.dmem_req_out), 32'(m_busy));
        chk("stall", 32'(lsu_stall_out), 32'(e_stall));
        chk("ld_valid", 32'(ld_valid_out), 32'(e_valid));
        chk("bus_err", 32'(bus_err_out), 32'(e_err));
        chk("misaligned", 32'(misaligned_out), 32'(e_mis));
        chk("ld_data", ld_data_out, e_ld_data);
        if (m_busy) begin
            chk("addr", bus.dmem_addr_out, e_addr);
            chk("we", 32'(bus.dmem_we_out), 32'(e_we));
            chk("wmask", 32'(bus.dmem_wmask_out), 32'(e_wmask));
            if (e_we) chk("wdata", bus.dmem_wdata_out, e_wdata);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d);
        ld_req_in = ld; st_req_in = st; load_size_in = sz;
        load_unsigned_in = uns; addr_in = a; store_data_in = d;
    endtask

    task automatic clear_req();
        ld_req_in = 1'b0; st_req_in = 1'b0;
    endtask

    // Load with ack on the first request cycle.
    task automatic quick_load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                              input logic [31:0] rd);
        issue(1'b1, 1'b0, sz, uns, a, 32'h0);
        step();
        clear_req();
        bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = rd;
        step();
        bus.dmem_ack_in = 1'b0;
    endtask

    initial begin
        int hi;
        bus.dmem_ack_in = 1'b0;
        bus.dmem_rdata_in = '0;

        step(); step();
        reset_in = 1'b1;
        step();
        chk("rst_req", 32'(bus.dmem_req_out), 32'd0);
        chk("rst_ld_data", ld_data_out, 32'h0);
        chk("rst_valid", 32'(ld_valid_out), 32'd0);
        chk("rst_err", 32'(bus_err_out), 32'd0);

        // Signed byte load, ack on first request cycle
        issue(1'b1, 1'b0, 2'd0, 1'b0, 32'h1003, 32'h0);
        step();
        clear_req();
        bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = 32'h80AA_BBCC;
        #1;
        chk("lb_req", 32'(bus.dmem_req_out), 32'd1);
        chk("lb_addr", bus.dmem_addr_out, 32'h1000);
        chk("lb_stall_ack", 32'(lsu_stall_out), 32'd0);
        step();
        bus.dmem_ack_in = 1'b0;
        chk("lb_data", ld_data_out, 32'hFFFF_FF80);
        chk("lb_valid", 32'(ld_valid_out), 32'd1);
        step();
        chk("lb_valid_pulse", 32'(ld_valid_out), 32'd0);

        // Halfword store
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF);
        #1 chk("sh_stall_idle", 32'(lsu_stall_out), 32'd1);
        step();
        chk("sh_addr", bus.dmem_addr_out, 32'h2000);
        chk("sh_mask", 32'(bus.dmem_wmask_out), 32'hC);
        chk("sh_wdata", bus.dmem_wdata_out, 32'hBEEF_BEEF);
        chk("sh_we", 32'(bus.dmem_we_out), 32'd1);
        clear_req();
        bus.dmem_ack_in = 1'b1;
        step();
        bus.dmem_ack_in = 1'b0;
        chk("sh_no_valid", 32'(ld_valid_out), 32'd0);

        // Byte store with a delayed ack
        issue(1'b0, 1'b1, 2'd0, 1'b0, 32'h3001, 32'h1234_5678);
        step();
        clear_req();
        step();
        chk("sb_mask", 32'(bus.dmem_wmask_out), 32'h2);
        chk("sb_wdata", bus.dmem_wdata_out, 32'h7878_7878);
        bus.dmem_ack_in = 1'b1;
        step();
        bus.dmem_ack_in = 1'b0;

        quick_load(2'd1, 1'b1, 32'h4002, 32'h8001_7FFF);
        chk("lhu_data", ld_data_out, 32'h0000_8001);
        quick_load(2'd1, 1'b0, 32'h4000, 32'h1234_8000);
        chk("lh_data", ld_data_out, 32'hFFFF_8000);
        quick_load(2'd0, 1'b1, 32'h5001, 32'h1122_3344);
        chk("lbu_data", ld_data_out, 32'h0000_0033);

        // Timeout with ack withheld
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h6000, 32'h0);
        step();
        clear_req();
        hi = 0;
        for (int i = 0; i < 40 && bus.dmem_req_out === 1'b1; i++) begin
            hi++;
            step();
        end
        chk("to_req_cycles", 32'(hi), 32'd15);
        chk("to_err", 32'(bus_err_out), 32'd1);
        chk("to_stall", 32'(lsu_stall_out), 32'd0);
        chk("to_ld_data_held", ld_data_out, 32'h0000_0033);
        step();
        chk("to_err_pulse", 32'(bus_err_out), 32'd0);

        // Ack on the last allowed cycle wins over timeout
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h7000, 32'h0);
        step();
        clear_req();
        repeat (14) step();
        bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = 32'hCAFE_F00D;
        step();
        bus.dmem_ack_in = 1'b0;
        chk("to_ack_data", ld_data_out, 32'hCAFE_F00D);
        chk("to_ack_valid", 32'(ld_valid_out), 32'd1);
        chk("to_ack_no_err", 32'(bus_err_out), 32'd0);

        // Load wins over store; requests during ACCESS ignored
        issue(1'b1, 1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'h99);
        step();
        chk("both_we", 32'(bus.dmem_we_out), 32'd0);
        chk("both_mask", 32'(bus.dmem_wmask_out), 32'h0);
        issue(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0080, 32'h77);
        step();
        chk("both_addr_held", bus.dmem_addr_out, 32'h0000_0040);
        chk("both_we_held", 32'(bus.dmem_we_out), 32'd0);
        clear_req();
        bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = 32'h55;
        step();
        bus.dmem_ack_in = 1'b0;
        chk("both_data", ld_data_out, 32'h55);
        step();

        // Reset in the 3rd wait cycle, then a late ack
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h8000, 32'h0);
        step();
        clear_req();
        step(); step();
        reset_in = 1'b0;
        step();
        chk("abort_req", 32'(bus.dmem_req_out), 32'd0);
        chk("abort_data", ld_data_out, 32'h0);
        reset_in = 1'b1;
        bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = 32'hDEAD_BEEF;
        #1 chk("late_stall", 32'(lsu_stall_out), 32'd0);
        step();
        bus.dmem_ack_in = 1'b0;
        chk("late_valid", 32'(ld_valid_out), 32'd0);
        chk("late_data", ld_data_out, 32'h0);

        // Misaligned word load and half store
`ifdef MSRV32_LSU_MISALIGN_TRAP_EN
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001, 32'h0);
        #1 chk("mis_stall", 32'(lsu_stall_out), 32'd0);
        step();
        clear_req();
        chk("mis_req", 32'(bus.dmem_req_out), 32'd0);
        chk("mis_pulse", 32'(misaligned_out), 32'd1);
        step();
        chk("mis_pulse_end", 32'(misaligned_out), 32'd0);
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h2003, 32'hABCD_1234);
        step();
        clear_req();
        chk("mis_sh_req", 32'(bus.dmem_req_out), 32'd0);
        chk("mis_sh_pulse", 32'(misaligned_out), 32'd1);
        step();
`else
        issue(1'b1, 1'b0, 2'd2, 1'b0, 32'h1001, 32'h0);
        #1 chk("mis_stall", 32'(lsu_stall_out), 32'd1);
        step();
        clear_req();
        chk("mis_req", 32'(bus.dmem_req_out), 32'd1);
        chk("mis_addr", bus.dmem_addr_out, 32'h1000);
        chk("mis_flag", 32'(misaligned_out), 32'd0);
        bus.dmem_ack_in = 1'b1; bus.dmem_rdata_in = 32'hA5A5_5A5A;
        step();
        bus.dmem_ack_in = 1'b0;
        chk("mis_data", ld_data_out, 32'hA5A5_5A5A);
        issue(1'b0, 1'b1, 2'd1, 1'b0, 32'h2003, 32'hABCD_1234);
        step();
        clear_req();
        chk("mis_sh_mask", 32'(bus.dmem_wmask_out), 32'hC);
        chk("mis_sh_wdata", bus.dmem_wdata_out, 32'h1234_1234);
        bus.dmem_ack_in = 1'b1;
        step();
        bus.dmem_ack_in = 1'b0;
`endif
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
